// File: rtl/pwm_gen.sv
// pwm_gen: registered PWM generator driven by an external 8-bit free-running
// counter. The duty value is double-buffered and only takes effect at period
// boundaries (rising edge of tcount). A wrap counter tracks boundaries and a
// sticky interrupt flags completed periods while the output is running.
module pwm_gen #(
    parameter int WRAP_W   = 16,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        count,
    input  logic              tcount,
    input  logic [7:0]        duty_in,
    input  logic              duty_wr,
    input  logic              out_en,
    input  logic              wrap_clr,
    input  logic              irq_ack,
    output logic              pwm,
    output logic              running,
    output logic              period_done,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              tcount_prev_q, tcount_prev_d;
    logic [7:0]        active_duty_q, active_duty_d;
    logic [7:0]        pending_duty_q, pending_duty_d;
    logic              pend_flag_q, pend_flag_d;
    logic              pwm_q, pwm_d;
    logic              running_q, running_d;
    logic              period_done_q, period_done_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              irq_q, irq_d;

    logic              boundary_s;
    logic              active_now_s;
    logic              active_next_s;

    // Boundary is the first cycle of a tcount high run, so a held tcount counts once.
    always_comb begin
        tcount_prev_d = tcount;
        boundary_s    = tcount & ~tcount_prev_q;
        active_now_s  = (state_q == ST_RUN) || (state_q == ST_STOP);
    end

    // Double-buffered duty: writes land in pending, transfer at a boundary,
    // and a write coinciding with a boundary bypasses straight to active.
    always_comb begin
        active_duty_d  = active_duty_q;
        pending_duty_d = pending_duty_q;
        pend_flag_d    = pend_flag_q;
        if (duty_wr) begin
            pending_duty_d = duty_in;
        end else begin
            pending_duty_d = pending_duty_q;
        end
        if (boundary_s) begin
            pend_flag_d = 1'b0;
            if (duty_wr) begin
                active_duty_d = duty_in;
            end else if (pend_flag_q) begin
                active_duty_d = pending_duty_q;
            end else begin
                active_duty_d = active_duty_q;
            end
        end else if (duty_wr) begin
            pend_flag_d = 1'b1;
        end else begin
            pend_flag_d = pend_flag_q;
        end
    end

    // Output enable FSM; SYNC and STOP align start/stop to period boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (out_en) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (!out_en) begin
                    state_d = ST_IDLE;
                end else if (boundary_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_RUN: begin
                if (!out_en) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOP: begin
                if (boundary_s) begin
                    state_d = ST_IDLE;
                end else if (out_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: compare against the duty in effect after this edge.
    always_comb begin
        active_next_s = (state_d == ST_RUN) || (state_d == ST_STOP);
        running_d     = active_next_s;
        period_done_d = boundary_s & active_now_s;
        if (active_next_s) begin
            pwm_d = (count < active_duty_d);
        end else begin
            pwm_d = IDLE_LVL;
        end
    end

    // Wrap counter and sticky interrupt; a set always wins over an ack.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        irq_d      = irq_q;
        if (wrap_clr) begin
            wrap_cnt_d = boundary_s ? WRAP_W'(1) : WRAP_W'(0);
        end else if (boundary_s) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
        if (period_done_q) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tcount_prev_q  <= 1'b0;
            active_duty_q  <= 8'd0;
            pending_duty_q <= 8'd0;
            pend_flag_q    <= 1'b0;
            pwm_q          <= IDLE_LVL;
            running_q      <= 1'b0;
            period_done_q  <= 1'b0;
            wrap_cnt_q     <= WRAP_W'(0);
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            tcount_prev_q  <= tcount_prev_d;
            active_duty_q  <= active_duty_d;
            pending_duty_q <= pending_duty_d;
            pend_flag_q    <= pend_flag_d;
            pwm_q          <= pwm_d;
            running_q      <= running_d;
            period_done_q  <= period_done_d;
            wrap_cnt_q     <= wrap_cnt_d;
            irq_q          <= irq_d;
        end
    end

    assign pwm         = pwm_q;
    assign running     = running_q;
    assign period_done = period_done_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed scenarios plus randomized traffic for pwm_gen, checked
// every cycle against a behavioural model and with period-level tallies.
module tb_pwm_gen;

    localparam int WRAP_W   = 8;
    localparam int WRAP_MOD = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        count = 8'd0;
    logic              tcount = 1'b0;
    logic [7:0]        duty_in = 8'd0;
    logic              duty_wr = 1'b0;
    logic              out_en = 1'b0;
    logic              wrap_clr = 1'b0;
    logic              irq_ack = 1'b0;
    logic              pwm;
    logic              running;
    logic              period_done;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_gen #(.WRAP_W(WRAP_W), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .rst(rst), .count(count), .tcount(tcount),
        .duty_in(duty_in), .duty_wr(duty_wr), .out_en(out_en),
        .wrap_clr(wrap_clr), .irq_ack(irq_ack), .pwm(pwm), .running(running),
        .period_done(period_done), .wrap_cnt(wrap_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 waiting for boundary, 2 running, 3 finishing.
    int       m_mode;
    int       m_wrap;
    bit [7:0] m_active, m_pend;
    bit       m_has_pend, m_tprev, m_pd, m_irq, m_pwm;
    bit [7:0] cnt_v = 8'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wrap = 0; m_active = 8'd0; m_pend = 8'd0;
        m_has_pend = 1'b0; m_tprev = 1'b0; m_pd = 1'b0; m_irq = 1'b0; m_pwm = 1'b0;
    endtask

    task automatic model_step();
        bit b;
        b = tcount && !m_tprev;
        m_irq = m_pd ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
        m_pd  = b && (m_mode >= 2);
        if (wrap_clr)  m_wrap = b ? 1 : 0;
        else if (b)    m_wrap = (m_wrap + 1) % WRAP_MOD;
        if (b) begin
            if (duty_wr)         m_active = duty_in;
            else if (m_has_pend) m_active = m_pend;
            m_has_pend = 1'b0;
        end else if (duty_wr) begin
            m_pend = duty_in;
            m_has_pend = 1'b1;
        end
        case (m_mode)
            0: if (out_en) m_mode = 1;
            1: if (!out_en) m_mode = 0; else if (b) m_mode = 2;
            2: if (!out_en) m_mode = 3;
            3: if (b) m_mode = 0; else if (out_en) m_mode = 2;
            default: m_mode = 0;
        endcase
        m_pwm   = (m_mode >= 2) ? (int'(count) < int'(m_active)) : 1'b0;
        m_tprev = tcount;
    endtask

    // One clock: step the model on the current inputs, then compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_val("pwm", pwm, m_pwm);
        check_val("running", running, (m_mode >= 2));
        check_val("period_done", period_done, m_pd);
        check_val("wrap_cnt", wrap_cnt, m_wrap);
        check_val("irq", irq, m_irq);
        duty_wr = 1'b0; wrap_clr = 1'b0; irq_ack = 1'b0;
    endtask

    task automatic free_tick();
        cnt_v  = cnt_v + 8'd1;
        count  = cnt_v;
        tcount = (cnt_v == 8'd0);
        tick();
    endtask

    task automatic align();
        for (int i = 0; i < 300 && cnt_v != 8'd255; i++) free_tick();
    endtask

    // One full period (counts 0..255) with up to two duty writes; tallies pwm and pulses.
    task automatic period_tally(input int w1, input bit [7:0] v1, input int w2, input bit [7:0] v2,
                                output int highs, output int pds);
        bit [7:0] nxt;
        align();
        highs = 0; pds = 0;
        for (int i = 0; i < 256; i++) begin
            nxt = cnt_v + 8'd1;
            if (int'(nxt) == w1) begin duty_in = v1; duty_wr = 1'b1; end
            else if (int'(nxt) == w2) begin duty_in = v2; duty_wr = 1'b1; end
            free_tick();
            highs += int'(pwm);
            pds   += int'(period_done);
        end
    endtask

    int h, p;

    initial begin
        model_reset();
        // Power-on reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_val("rst_pwm", pwm, 1'b0);
        check_val("rst_running", running, 1'b0);
        check_val("rst_wrap", wrap_cnt, 0);
        check_val("rst_irq", irq, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Basic PWM at duty 64; entry boundary gives no period_done.
        out_en = 1'b1; duty_in = 8'd64; duty_wr = 1'b1;
        free_tick();
        period_tally(-1, 8'd0, -1, 8'd0, h, p);
        check_val("basic_high_p1", h, 64);
        check_val("basic_pd_p1", p, 0);
        period_tally(-1, 8'd0, -1, 8'd0, h, p);
        check_val("basic_high_p2", h, 64);
        check_val("basic_pd_p2", p, 1);

        // Duty 0 over three periods, then duty 255.
        period_tally(20, 8'd0, -1, 8'd0, h, p);
        check_val("dz_write_period", h, 64);
        for (int k = 0; k < 3; k++) begin
            period_tally(-1, 8'd0, -1, 8'd0, h, p);
            check_val("duty0_high", h, 0);
        end
        period_tally(30, 8'd255, -1, 8'd0, h, p);
        check_val("d255_write_period", h, 0);
        period_tally(-1, 8'd0, -1, 8'd0, h, p);
        check_val("duty255_high", h, 255);

        // Buffered update: last write wins and waits for the boundary.
        period_tally(40, 8'd128, -1, 8'd0, h, p);
        check_val("d128_write_period", h, 255);
        period_tally(10, 8'd32, 100, 8'd200, h, p);
        check_val("buf_current", h, 128);
        period_tally(-1, 8'd0, -1, 8'd0, h, p);
        check_val("buf_next", h, 200);
        period_tally(0, 8'd16, -1, 8'd0, h, p);
        check_val("bypass_same_cycle", h, 16);

        // Held tcount: counter loaded to 255 and held, exactly one boundary.
        for (int i = 0; i < 300 && cnt_v != 8'd200; i++) free_tick();
        wrap_clr = 1'b1;
        free_tick();
        p = 0;
        for (int i = 0; i < 6; i++) begin
            count = (i < 5) ? 8'd255 : 8'd0; tcount = 1'b1;
            tick();
            p += int'(period_done);
        end
        cnt_v = 8'd0;
        free_tick();
        p += int'(period_done);
        check_val("held_wrap", wrap_cnt, 1);
        check_val("held_pd", p, 1);

        // Ack coincident with period_done leaves irq set; a later ack clears it.
        align();
        free_tick();
        check_val("pd_seen", period_done, 1'b1);
        irq_ack = 1'b1;
        free_tick();
        check_val("irq_ack_coincident", irq, 1'b1);
        irq_ack = 1'b1;
        free_tick();
        check_val("irq_ack_clear", irq, 1'b0);

        // Dropping out_en mid-period finishes the period, then idles.
        for (int i = 0; i < 300 && cnt_v != 8'd49; i++) free_tick();
        out_en = 1'b0;
        free_tick();
        align();
        check_val("stop_still_running", running, 1'b1);
        free_tick();
        check_val("stop_idle", running, 1'b0);
        check_val("stop_pwm_idle", pwm, 1'b0);

        // Wrap counter rollover and clear-with-boundary.
        wrap_clr = 1'b1; tcount = 1'b0;
        tick();
        check_val("wrap_clr", wrap_cnt, 0);
        for (int i = 0; i < 254; i++) begin
            tcount = 1'b1; tick();
            tcount = 1'b0; tick();
        end
        check_val("wrap_254", wrap_cnt, 254);
        tcount = 1'b1; tick(); tcount = 1'b0; tick();
        check_val("wrap_255", wrap_cnt, 255);
        tcount = 1'b1; tick(); tcount = 1'b0; tick();
        check_val("wrap_rollover", wrap_cnt, 0);
        tcount = 1'b1; tick(); tcount = 1'b0; tick();
        tcount = 1'b1; wrap_clr = 1'b1; tick();
        check_val("wrap_clr_boundary", wrap_cnt, 1);
        tcount = 1'b0; tick();

        // Randomized traffic: counter jumps, extra tcount pulses, writes, acks.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cnt_v = 8'($urandom); count = cnt_v; tcount = 1'b0;
                duty_wr = ($urandom_range(0, 7) == 0);
                duty_in = 8'($urandom);
                tick();
            end else begin
                if ($urandom_range(0, 63) == 0) out_en = ~out_en;
                duty_wr  = ($urandom_range(0, 7) == 0);
                duty_in  = 8'($urandom);
                wrap_clr = ($urandom_range(0, 99) == 0);
                irq_ack  = ($urandom_range(0, 7) == 0);
                if (r < 6) begin
                    count = cnt_v; tcount = 1'b1;
                    tick();
                end else begin
                    free_tick();
                end
            end
        end

        // Asynchronous reset in RUN with pwm high.
        out_en = 1'b1;
        period_tally(5, 8'd128, -1, 8'd0, h, p);
        free_tick(); free_tick(); free_tick();
        check_val("pre_rst_pwm", pwm, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("async_pwm", pwm, 1'b0);
        check_val("async_running", running, 1'b0);
        check_val("async_wrap", wrap_cnt, 0);
        check_val("async_irq", irq, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        // Without a boundary the FSM stays out of RUN after reset.
        for (int i = 0; i < 5; i++) free_tick();
        check_val("post_rst_not_running", running, 1'b0);
        align();
        free_tick();
        check_val("post_rst_running", running, 1'b1);
        check_val("post_rst_duty_lost", pwm, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
